// File: rtl/sub_serial_16.sv
// sub_serial_16: bit-serial two's-complement subtractor, diff = a - b - bin.
// One full-subtractor cell processes one bit per clock, LSB first.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        operand handshake (a, b, bin)
//   out_valid/out_ready      result handshake (diff, bout, ovf)
//   diff                     a - b - bin modulo 2^WIDTH
//   bout                     borrow-out (unsigned a < b + bin)
//   ovf                      signed overflow of the subtraction
module sub_serial_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
  logic [WIDTH-1:0]   diff_sh_q,   diff_sh_d;
  logic [WIDTH-1:0]   diff_q,      diff_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               borrow_q,    borrow_d;
  logic               a_msb_q,     a_msb_d;
  logic               b_msb_q,     b_msb_d;
  logic               bout_q,      bout_d;
  logic               ovf_q,       ovf_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               x_bit;
  logic               y_bit;
  logic               d_bit;
  logic               borrow_nxt;

  // Next-state, full-subtractor cell and shift datapath.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    diff_sh_d   = diff_sh_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    x_bit      = a_sh_q[0];
    y_bit      = b_sh_q[0];
    d_bit      = x_bit ^ y_bit ^ borrow_q;
    borrow_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d     = a;
          b_sh_d     = b;
          borrow_d   = bin;
          cnt_d      = '0;
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
        diff_sh_d = {d_bit, diff_sh_q[WIDTH-1:1]};
        borrow_d  = borrow_nxt;
        cnt_d     = cnt_q + CNT_W'(1);
        // Last bit: publish the result in one step so diff only changes on completion.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d      = {d_bit, diff_sh_q[WIDTH-1:1]};
          bout_d      = borrow_nxt;
          ovf_d       = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_sh_q   <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      diff_sh_q   <= diff_sh_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_serial_16.sv
// tb_sub_serial_16: scoreboard bench for sub_serial_16.
// Expected results are pushed when an operand is accepted and popped when out_valid rises.
module tb_sub_serial_16;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  sub_serial_16 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: widen to WIDTH+1 bits so the top bit is the unsigned borrow.
  function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mbin);
    logic [WIDTH:0] full;
    res_t r;
    full   = {1'b0, ma} - {1'b0, mb} - (WIDTH+1)'(mbin);
    r.diff = full[WIDTH-1:0];
    r.bout = full[WIDTH];
    r.ovf  = (ma[WIDTH-1] ^ mb[WIDTH-1]) & (ma[WIDTH-1] ^ full[WIDTH-1]);
    return r;
  endfunction

  // Present operands, wait for acceptance, push the expected result.
  task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb, input logic sbin);
    int n;
    in_valid = 1'b1;
    a        = sa;
    b        = sb;
    bin      = sbin;
    n        = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model(sa, sb, sbin));
  endtask

  // Cycles from the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_timeout", 32'd0, 32'd1);
  endtask

  // Pop the scoreboard, compare, then consume the result.
  task automatic drain(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
      chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
      chk({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int stall;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbin;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff",      32'(diff),      32'd0);
    chk("rst_bout",      32'(bout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);

    // Basic positive difference and latency
    send(16'h0005, 16'h0003, 1'b0);
    chk("t1_busy_in_ready", 32'(in_ready), 32'd0);
    wait_out(lat);
    chk("t1_latency", 32'(lat), 32'd16);
    chk("t1_diff", 32'(diff), 32'h0002);
    drain("t1");

    // Negative results / borrow-in
    send(16'h0003, 16'h0005, 1'b0);
    wait_out(lat);
    chk("t2a_diff", 32'(diff), 32'hFFFE);
    chk("t2a_bout", 32'(bout), 32'd1);
    drain("t2a");
    send(16'h0000, 16'h0000, 1'b1);
    wait_out(lat);
    chk("t2b_diff", 32'(diff), 32'hFFFF);
    chk("t2b_bout", 32'(bout), 32'd1);
    drain("t2b");

    // Signed overflow corners
    send(16'h8000, 16'h0001, 1'b0);
    wait_out(lat);
    chk("t3a_diff", 32'(diff), 32'h7FFF);
    chk("t3a_ovf",  32'(ovf),  32'd1);
    chk("t3a_bout", 32'(bout), 32'd0);
    drain("t3a");
    send(16'h7FFF, 16'hFFFF, 1'b0);
    wait_out(lat);
    chk("t3b_diff", 32'(diff), 32'h8000);
    chk("t3b_bout", 32'(bout), 32'd1);
    chk("t3b_ovf",  32'(ovf),  32'd1);
    drain("t3b");

    // Backpressure: results held, new request not taken while DONE
    send(16'h1234, 16'h0234, 1'b0);
    wait_out(lat);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 16'hAAAA;
    b         = 16'h5555;
    bin       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_diff",  32'(diff),      32'h1000);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_in_ready",   32'(in_ready),  32'd0);
    end
    drain("t4");
    chk("t4_idle_in_ready", 32'(in_ready), 32'd1);
    send(16'hAAAA, 16'h5555, 1'b1);
    wait_out(lat);
    chk("t4b_latency", 32'(lat), 32'd16);
    drain("t4b");

    // Reset in the middle of RUN drops the operation
    send(16'h00F0, 16'h000F, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("t5_in_ready",  32'(in_ready),  32'd1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_diff",      32'(diff),      32'd0);
    tick();
    tick();
    chk("t5_no_result", 32'(out_valid), 32'd0);
    send(16'h1000, 16'h0001, 1'b0);
    wait_out(lat);
    chk("t5_latency", 32'(lat), 32'd16);
    chk("t5_diff_after", 32'(diff), 32'h0FFF);
    drain("t5");

    // Random back-to-back with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rbin = 1'($urandom);
      send(ra, rb, rbin);
      wait_out(lat);
      chk("rnd_latency", 32'(lat), 32'd16);
      stall = $urandom_range(0, 3);
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) tick();
      drain("rnd");
    end

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
